// File: rtl/pico_pkg.sv
// pico_pkg
// Shared types for the pico_mips multi-cycle control unit.
//   opcode_e : architectural opcode values (low three opcode bits)
//   state_e  : control FSM states
//   ctrl_t   : the seven datapath control lines, grouped
package pico_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_IMM  = 3'd1,
        OP_MULT = 3'd2,
        OP_BRAN = 3'd3,
        OP_BEQ  = 3'd4,
        OP_NOP  = 3'd5
    } opcode_e;

    typedef enum logic [1:0] {
        S_EXEC  = 2'd0,
        S_MWAIT = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic alu_flag;
        logic alu_ctrl;
        logic mult_flag;
        logic ram_flag;
        logic bran;
        logic nw;
        logic pc_en;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pico_op_decode.sv
// pico_op_decode
// Combinational opcode decoder for the S_EXEC state.
// Ports:
//   instr_valid : opcode is valid this cycle
//   opcode      : instruction opcode (OP_W bits)
//   z_flag      : ALU zero flag, qualifies BEQ
//   ctrl        : control lines for this cycle
//   illegal     : undefined opcode (executes as NOP)
//   start_mult  : MULT needs extra wait cycles (MULT_LAT > 1)
//   take_branch : BRAN or taken BEQ; a flush bubble follows
module pico_op_decode
    import pico_pkg::*;
#(
    parameter int OP_W     = 3,
    parameter int MULT_LAT = 2
) (
    input  logic            instr_valid,
    input  logic [OP_W-1:0] opcode,
    input  logic            z_flag,
    output ctrl_t           ctrl,
    output logic            illegal,
    output logic            start_mult,
    output logic            take_branch
);

    // Any opcode at or above 6 (including any set upper bits when OP_W > 3)
    // is undefined.
    logic    in_range;
    opcode_e op;

    assign in_range = (opcode < OP_W'(6));
    assign op       = opcode_e'(opcode[2:0]);

    always_comb begin
        ctrl        = CTRL_NONE;
        illegal     = 1'b0;
        start_mult  = 1'b0;
        take_branch = 1'b0;
        if (instr_valid) begin
            if (!in_range) begin
                illegal    = 1'b1;
                ctrl.nw    = 1'b1;
                ctrl.pc_en = 1'b1;
            end else begin
                case (op)
                    OP_ADD: begin
                        ctrl.alu_flag = 1'b1;
                        ctrl.alu_ctrl = 1'b1;
                        ctrl.ram_flag = 1'b1;
                        ctrl.pc_en    = 1'b1;
                    end
                    OP_IMM: begin
                        ctrl.ram_flag = 1'b1;
                        ctrl.pc_en    = 1'b1;
                    end
                    OP_MULT: begin
                        ctrl.mult_flag = 1'b1;
                        if (MULT_LAT > 1) begin
                            // Write-back and PC advance wait for the last cycle.
                            start_mult = 1'b1;
                        end else begin
                            ctrl.ram_flag = 1'b1;
                            ctrl.pc_en    = 1'b1;
                        end
                    end
                    OP_BRAN: begin
                        ctrl.bran   = 1'b1;
                        ctrl.nw     = 1'b1;
                        take_branch = 1'b1;
                    end
                    OP_BEQ: begin
                        if (z_flag) begin
                            ctrl.bran   = 1'b1;
                            ctrl.nw     = 1'b1;
                            take_branch = 1'b1;
                        end else begin
                            ctrl.pc_en = 1'b1;
                        end
                    end
                    OP_NOP: begin
                        ctrl.pc_en = 1'b1;
                    end
                    default: begin
                        ctrl = CTRL_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/pico_ctrl_fsm.sv
// pico_ctrl_fsm
// Multi-cycle control unit for the pico_mips datapath: single-cycle ALU ops,
// multi-cycle MULT with stall, and branches followed by a one-cycle flush.
// Ports:
//   clk, n_reset      : clock, synchronous active-low reset
//   instr_valid       : opcode valid this cycle
//   opcode            : instruction opcode (OP_W bits)
//   z_flag            : ALU zero flag for BEQ
//   alu_flag          : ALU result onto write-back bus
//   alu_ctrl          : 1 = add, 0 = pass immediate
//   mult_flag         : multiplier enable / select
//   ram_flag          : register-file write enable
//   bran              : PC loads branch target
//   nw                : suppress architectural write
//   pc_en             : PC increments
//   busy              : stalling (MULT wait or flush)
//   illegal           : pulse for an undefined opcode
module pico_ctrl_fsm
    import pico_pkg::*;
#(
    parameter int OP_W     = 3,
    parameter int MULT_LAT = 2
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            instr_valid,
    input  logic [OP_W-1:0] opcode,
    input  logic            z_flag,
    output logic            alu_flag,
    output logic            alu_ctrl,
    output logic            mult_flag,
    output logic            ram_flag,
    output logic            bran,
    output logic            nw,
    output logic            pc_en,
    output logic            busy,
    output logic            illegal
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_start_mult;
    logic  dec_take_branch;

    ctrl_t ctrl;
    logic  busy_int;
    logic  illegal_int;

    pico_op_decode #(
        .OP_W     (OP_W),
        .MULT_LAT (MULT_LAT)
    ) u_decode (
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .z_flag      (z_flag),
        .ctrl        (dec_ctrl),
        .illegal     (dec_illegal),
        .start_mult  (dec_start_mult),
        .take_branch (dec_take_branch)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg <= S_EXEC;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        ctrl        = CTRL_NONE;
        busy_int    = 1'b0;
        illegal_int = 1'b0;
        case (state_reg)
            S_EXEC: begin
                ctrl        = dec_ctrl;
                illegal_int = dec_illegal;
                if (dec_start_mult) begin
                    // First MULT cycle counts as cycle 0; wait cycles follow.
                    busy_int   = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = S_MWAIT;
                end else if (dec_take_branch) begin
                    state_next = S_FLUSH;
                end
            end
            S_MWAIT: begin
                ctrl.mult_flag = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    ctrl.ram_flag = 1'b1;
                    ctrl.pc_en    = 1'b1;
                    cnt_next      = '0;
                    state_next    = S_EXEC;
                end else begin
                    busy_int = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                // Bubble: the opcode fetched during the PC reload is dropped.
                ctrl.nw    = 1'b1;
                busy_int   = 1'b1;
                state_next = S_EXEC;
            end
            default: begin
                state_next = S_EXEC;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are held low for the whole reset cycle so an abandoned MULT
    // or flush never leaks a write enable.
    assign alu_flag  = n_reset & ctrl.alu_flag;
    assign alu_ctrl  = n_reset & ctrl.alu_ctrl;
    assign mult_flag = n_reset & ctrl.mult_flag;
    assign ram_flag  = n_reset & ctrl.ram_flag;
    assign bran      = n_reset & ctrl.bran;
    assign nw        = n_reset & ctrl.nw;
    assign pc_en     = n_reset & ctrl.pc_en;
    assign busy      = n_reset & busy_int;
    assign illegal   = n_reset & illegal_int;

endmodule

// File: tb/tb_pico_ctrl_fsm.sv
// Testbench for pico_ctrl_fsm. Three instances share the stimulus with
// MULT_LAT = 3, 4 and 1. Outputs are packed as
// {alu_flag, alu_ctrl, mult_flag, ram_flag, bran, nw, pc_en, busy, illegal}.
module tb_pico_ctrl_fsm;

    logic       clk;
    logic       n_reset;
    logic       instr_valid;
    logic [2:0] opcode;
    logic       z_flag;

    logic [8:0] obs [3];

    logic a0, c0, m0, r0, b0, n0, p0, y0, i0;
    logic a1, c1, m1, r1, b1, n1, p1, y1, i1;
    logic a2, c2, m2, r2, b2, n2, p2, y2, i2;

    pico_ctrl_fsm #(.OP_W(3), .MULT_LAT(3)) dut0 (
        .clk(clk), .n_reset(n_reset), .instr_valid(instr_valid), .opcode(opcode), .z_flag(z_flag),
        .alu_flag(a0), .alu_ctrl(c0), .mult_flag(m0), .ram_flag(r0), .bran(b0), .nw(n0),
        .pc_en(p0), .busy(y0), .illegal(i0));
    pico_ctrl_fsm #(.OP_W(3), .MULT_LAT(4)) dut1 (
        .clk(clk), .n_reset(n_reset), .instr_valid(instr_valid), .opcode(opcode), .z_flag(z_flag),
        .alu_flag(a1), .alu_ctrl(c1), .mult_flag(m1), .ram_flag(r1), .bran(b1), .nw(n1),
        .pc_en(p1), .busy(y1), .illegal(i1));
    pico_ctrl_fsm #(.OP_W(3), .MULT_LAT(1)) dut2 (
        .clk(clk), .n_reset(n_reset), .instr_valid(instr_valid), .opcode(opcode), .z_flag(z_flag),
        .alu_flag(a2), .alu_ctrl(c2), .mult_flag(m2), .ram_flag(r2), .bran(b2), .nw(n2),
        .pc_en(p2), .busy(y2), .illegal(i2));

    assign obs[0] = {a0, c0, m0, r0, b0, n0, p0, y0, i0};
    assign obs[1] = {a1, c1, m1, r1, b1, n1, p1, y1, i1};
    assign obs[2] = {a2, c2, m2, r2, b2, n2, p2, y2, i2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, how many multiply cycles are still owed
    // after the current one, and whether a flush bubble is pending.
    int lat [3]   = '{3, 4, 1};
    int mleft [3] = '{0, 0, 0};
    bit flush [3] = '{1'b0, 1'b0, 1'b0};

    localparam logic [8:0] V_ZERO = 9'b000000000;
    localparam logic [8:0] V_ADD  = 9'b110100100;
    localparam logic [8:0] V_IMM  = 9'b000100100;
    localparam logic [8:0] V_NOP  = 9'b000000100;
    localparam logic [8:0] V_ILL  = 9'b000001101;
    localparam logic [8:0] V_BR   = 9'b000011000;
    localparam logic [8:0] V_FL   = 9'b000001010;
    localparam logic [8:0] V_MWT  = 9'b001000010;
    localparam logic [8:0] V_MEND = 9'b001100100;

    function automatic logic [8:0] expect_out(int k);
        logic [8:0] e;
        e = V_ZERO;
        if (!n_reset)           e = V_ZERO;
        else if (flush[k])      e = V_FL;
        else if (mleft[k] == 1) e = V_MEND;
        else if (mleft[k] > 1)  e = V_MWT;
        else if (instr_valid) begin
            case (opcode)
                3'd0: e = V_ADD;
                3'd1: e = V_IMM;
                3'd2: e = (lat[k] == 1) ? V_MEND : V_MWT;
                3'd3: e = V_BR;
                3'd4: e = z_flag ? V_BR : V_NOP;
                3'd5: e = V_NOP;
                default: e = V_ILL;
            endcase
        end
        return e;
    endfunction

    // Advance the clock by one edge, update the model with the inputs that
    // were stable at that edge, and log the transaction.
    task automatic tick();
        @(posedge clk);
        $display("t=%0t rst_n=%b v=%b op=%0d z=%b out0=%b out1=%b out2=%b",
                 $time, n_reset, instr_valid, opcode, z_flag, obs[0], obs[1], obs[2]);
        for (int k = 0; k < 3; k++) begin
            if (!n_reset) begin
                mleft[k] = 0;
                flush[k] = 1'b0;
            end else if (flush[k]) begin
                flush[k] = 1'b0;
            end else if (mleft[k] > 0) begin
                mleft[k] = mleft[k] - 1;
            end else if (instr_valid) begin
                if (opcode == 3'd2 && lat[k] > 1) mleft[k] = lat[k] - 1;
                if (opcode == 3'd3 || (opcode == 3'd4 && z_flag)) flush[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset();
        n_reset = 1'b0; instr_valid = 1'b1; opcode = 3'd0; z_flag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== V_ZERO) begin
                    bad++;
                    $display("FAIL reset dut%0d cyc%0d: got %b want %b", k, c, obs[k], V_ZERO);
                end
            end
            tick();
        end
        n_reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== V_ADD) begin
                bad++;
                $display("FAIL reset_first_add dut%0d: got %b want %b", k, obs[k], V_ADD);
            end
        end
        tick();
        drain();
    endtask

    task automatic test_sequence();
        logic [2:0] ops [4];
        logic [8:0] want [4];
        ops  = '{3'd1, 3'd0, 3'd5, 3'd7};
        want = '{V_IMM, V_ADD, V_NOP, V_ILL};
        instr_valid = 1'b1; z_flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            opcode = ops[c];
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== want[c]) begin
                    bad++;
                    $display("FAIL seq dut%0d cyc%0d: got %b want %b", k, c, obs[k], want[c]);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_mult();
        logic [8:0] want0 [4];
        want0 = '{V_MWT, V_MWT, V_MEND, V_ADD};
        instr_valid = 1'b1; z_flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            // MULT first; afterwards present ADD, which lat-3 ignores until done.
            opcode = (c == 0) ? 3'd2 : 3'd0;
            @(negedge clk);
            total++;
            if (obs[0] !== want0[c]) begin
                bad++;
                $display("FAIL mult_lat3 cyc%0d: got %b want %b", c, obs[0], want0[c]);
            end
            for (int k = 1; k < 3; k++) begin
                total++;
                if (obs[k] !== expect_out(k)) begin
                    bad++;
                    $display("FAIL mult_model dut%0d cyc%0d: got %b want %b", k, c, obs[k], expect_out(k));
                end
            end
            tick();
        end
        drain();
        // Single-cycle multiplier build.
        opcode = 3'd2; instr_valid = 1'b1;
        @(negedge clk);
        total++;
        if (obs[2] !== V_MEND) begin
            bad++;
            $display("FAIL mult_lat1: got %b want %b", obs[2], V_MEND);
        end
        tick();
        drain();
    endtask

    task automatic test_branch();
        logic [8:0] want [2];
        want = '{V_BR, V_FL};
        instr_valid = 1'b1; z_flag = 1'b1;
        for (int c = 0; c < 2; c++) begin
            opcode = (c == 0) ? 3'd4 : 3'd0;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== want[c]) begin
                    bad++;
                    $display("FAIL beq_taken dut%0d cyc%0d: got %b want %b", k, c, obs[k], want[c]);
                end
            end
            tick();
        end
        z_flag = 1'b0;
        for (int c = 0; c < 2; c++) begin
            opcode = (c == 0) ? 3'd4 : 3'd0;
            @(negedge clk);
            total++;
            if (obs[0] !== ((c == 0) ? V_NOP : V_ADD)) begin
                bad++;
                $display("FAIL beq_not_taken cyc%0d: got %b want %b", c, obs[0], (c == 0) ? V_NOP : V_ADD);
            end
            tick();
        end
        opcode = 3'd3;
        @(negedge clk);
        total++;
        if (obs[1] !== V_BR) begin
            bad++;
            $display("FAIL bran: got %b want %b", obs[1], V_BR);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_mult();
        logic [8:0] want1 [4];
        want1 = '{V_MWT, V_MWT, V_MWT, V_MEND};
        instr_valid = 1'b1; opcode = 3'd2; z_flag = 1'b0;
        tick();
        n_reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (obs[1][5] !== 1'b0) begin
                bad++;
                $display("FAIL mid_mult_reset cyc%0d: ram_flag got %b want 0", c, obs[1][5]);
            end
            tick();
        end
        n_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            opcode = (c == 0) ? 3'd2 : 3'd5;
            @(negedge clk);
            total++;
            if (obs[1] !== want1[c]) begin
                bad++;
                $display("FAIL mult_after_reset cyc%0d: got %b want %b", c, obs[1], want1[c]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_idle();
        instr_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            opcode = 3'($urandom_range(0, 7));
            z_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== V_ZERO) begin
                    bad++;
                    $display("FAIL idle dut%0d cyc%0d: got %b want %b", k, c, obs[k], V_ZERO);
                end
            end
            tick();
        end
        // No state change: an ADD decodes at once.
        instr_valid = 1'b1; opcode = 3'd0;
        @(negedge clk);
        total++;
        if (obs[1] !== V_ADD) begin
            bad++;
            $display("FAIL idle_then_add: got %b want %b", obs[1], V_ADD);
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            n_reset     = ($urandom_range(0, 39) != 0);
            instr_valid = ($urandom_range(0, 4) != 0);
            opcode      = 3'($urandom_range(0, 7));
            z_flag      = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (obs[k] !== expect_out(k)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got %b want %b", k, c, obs[k], expect_out(k));
                end
                total++;
                if ((obs[k][5] & obs[k][3]) || (obs[k][4] & obs[k][2])) begin
                    bad++;
                    $display("FAIL invariant dut%0d cyc%0d: got %b want no ram&nw or bran&pc_en", k, c, obs[k]);
                end
            end
            tick();
        end
        n_reset = 1'b1;
        drain();
    endtask

    initial begin
        n_reset = 1'b0; instr_valid = 1'b0; opcode = 3'd0; z_flag = 1'b0;
        test_reset();
        test_sequence();
        test_mult();
        test_branch();
        test_reset_mid_mult();
        test_idle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
